bcd_display_scan_2digit: RTL and testbench

Two-digit multiplexed 7-segment display driver that consumes the packed BCD digit pair (`high`, `low`) produced by the up/down BCD counters and scans it onto a shared segment bus with one anode per digit. It snapshots both digits once per frame so a counter update never mixes digits within one frame, blanks a leading zero, and flags invalid BCD codes. It sits between the counter block and the board I/O pins.

---
 rtl/bcd_disp_pkg.sv | 39 +++
 rtl/bcd_seg7_decode.sv | 30 +++
 rtl/bcd_display_scan_2digit.sv | 148 ++++++++++++++
 tb/tb_bcd_display_scan_2digit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared constants for the 2-digit BCD display scanner: segment patterns,
// scan state encoding and the "all off" output values for each polarity.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } disp_state_e;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  localparam logic [6:0] SEG_OFF_AH = 7'h00;
  localparam logic [6:0] SEG_OFF_AL = 7'h7F;
  localparam logic [1:0] AN_OFF_AH  = 2'b00;
  localparam logic [1:0] AN_OFF_AL  = 2'b11;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic [6:0] seg_off(input bit active_low);
    return active_low ? SEG_OFF_AL : SEG_OFF_AH;
  endfunction

  function automatic logic [1:0] an_off(input bit active_low);
    return active_low ? AN_OFF_AL : AN_OFF_AH;
  endfunction

endpackage

// File: rtl/bcd_seg7_decode.sv
// BCD to 7-segment decoder, active-high output; codes 10-15 show a dash
// and raise invalid.
module bcd_seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg,
  output logic       invalid
);

  always_comb begin
    seg = SEG_DASH;
    unique case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

  assign invalid = (digit > BCD_MAX);

endmodule

// File: rtl/bcd_display_scan_2digit.sv
// Two-digit multiplexed 7-segment scanner: snapshots the digit pair once per
// frame, lights low then high digit SCAN_DIV cycles each, blanks leading zero.
module bcd_display_scan_2digit
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 4,
  parameter bit          BLANK_LZ   = 1'b1,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] high,
  input  logic [3:0] low,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done,
  output logic       bcd_err
);

  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  disp_state_e      state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [3:0]       sh_hi_q, sh_hi_d;
  logic [3:0]       sh_lo_q, sh_lo_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             fd_q, fd_d;
  logic             err_q, err_d;

  logic [3:0]       dec_in;
  logic [6:0]       dec_seg;
  logic             dec_inv;
  logic             snap;
  logic [6:0]       seg_ah;
  logic [1:0]       an_ah;

  // Decoder input follows the next state so the output registers load the
  // digit that will be shown during the coming cycle.
  assign dec_in = (state_d == ST_HIGH) ? sh_hi_d : sh_lo_d;

  bcd_seg7_decode u_dec (
    .digit   (dec_in),
    .seg     (dec_seg),
    .invalid (dec_inv)
  );

  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    snap      = 1'b0;
    fd_d      = 1'b0;
    if (!enable) begin
      state_d   = ST_OFF;
      div_cnt_d = '0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          snap      = 1'b1;
          state_d   = ST_LOW;
          div_cnt_d = '0;
        end
        ST_LOW: begin
          if (div_cnt_q == DIV_LAST) begin
            state_d   = ST_HIGH;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        ST_HIGH: begin
          if (div_cnt_q == DIV_LAST) begin
            snap      = 1'b1;
            fd_d      = 1'b1;
            state_d   = ST_LOW;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = div_cnt_q + 1'b1;
          end
        end
        default: begin
          state_d   = ST_OFF;
          div_cnt_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    sh_hi_d = snap ? high : sh_hi_q;
    sh_lo_d = snap ? low  : sh_lo_q;
    // At a snapshot the next state is LOW, so the decoder sees the new low.
    err_d   = snap ? (dec_inv | (sh_hi_d > BCD_MAX)) : err_q;
  end

  always_comb begin
    seg_ah = 7'h00;
    an_ah  = 2'b00;
    unique case (state_d)
      ST_LOW: begin
        seg_ah = dec_seg;
        an_ah  = 2'b01;
      end
      ST_HIGH: begin
        if (!(BLANK_LZ && (sh_hi_d == 4'd0))) begin
          seg_ah = dec_seg;
          an_ah  = 2'b10;
        end
      end
      default: begin
        seg_ah = 7'h00;
        an_ah  = 2'b00;
      end
    endcase
    seg_d = ACTIVE_LOW ? ~seg_ah : seg_ah;
    an_d  = ACTIVE_LOW ? ~an_ah  : an_ah;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_OFF;
      div_cnt_q <= '0;
      sh_hi_q   <= '0;
      sh_lo_q   <= '0;
      seg_q     <= seg_off(ACTIVE_LOW);
      an_q      <= an_off(ACTIVE_LOW);
      fd_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      sh_hi_q   <= sh_hi_d;
      sh_lo_q   <= sh_lo_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
      err_q     <= err_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;
  assign bcd_err    = err_q;

endmodule

// File: tb/tb_bcd_display_scan_2digit.sv
// Scoreboard bench: stimulus pushes hand-computed per-cycle expectations,
// a monitor pops and compares one entry after every rising edge.
module tb_bcd_display_scan_2digit;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] high, low;
  logic       enable;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       fd_a, fd_b, err_a, err_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  // Main config: SCAN_DIV=4, blanking on, active-low.
  bcd_display_scan_2digit #(.SCAN_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut_a (
    .clock(clock), .reset(reset), .high(high), .low(low), .enable(enable),
    .seg(seg_a), .an(an_a), .frame_done(fd_a), .bcd_err(err_a)
  );

  // Same timing with leading-zero blanking off.
  bcd_display_scan_2digit #(.SCAN_DIV(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_b (
    .clock(clock), .reset(reset), .high(high), .low(low), .enable(enable),
    .seg(seg_b), .an(an_b), .frame_done(fd_b), .bcd_err(err_b)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic [6:0] segb;
    logic [1:0] anb;
    logic       fd;
    logic       err;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("seg",     {1'b0, seg_a}, {1'b0, e.seg});
        chk("an",      {6'b0, an_a},  {6'b0, e.an});
        chk("fd",      {7'b0, fd_a},  {7'b0, e.fd});
        chk("err",     {7'b0, err_a}, {7'b0, e.err});
        chk("seg_nlz", {1'b0, seg_b}, {1'b0, e.segb});
        chk("an_nlz",  {6'b0, an_b},  {6'b0, e.anb});
        chk("fd_nlz",  {7'b0, fd_b},  {7'b0, e.fd});
      end
    end
  end

  task automatic tick(input exp_t e);
    sb.push_back(e);
    @(negedge clock);
  endtask

  task automatic slot2(input int n, input logic [6:0] s, input logic [1:0] a,
                       input logic [6:0] sb_, input logic [1:0] ab,
                       input logic fd0, input logic err);
    for (int i = 0; i < n; i++) tick('{s, a, sb_, ab, (i == 0) ? fd0 : 1'b0, err});
  endtask

  task automatic slot(input int n, input logic [6:0] s, input logic [1:0] a,
                      input logic fd0, input logic err);
    slot2(n, s, a, s, a, fd0, err);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; high = 4'd4; low = 4'd7;
    // Power-up: held in reset with enable high.
    slot(3, 7'h7F, 2'b11, 1'b0, 1'b0);
    reset = 1'b1; enable = 1'b0;
    slot(1, 7'h7F, 2'b11, 1'b0, 1'b0);

    // Basic scan 4/7: first LOW one clock after enable, no frame_done.
    enable = 1'b1;
    slot(4, 7'h78, 2'b10, 1'b0, 1'b0);
    slot(4, 7'h19, 2'b01, 1'b0, 1'b0);

    // Leading zero 0/5: blanked on A, '0' shown on B.
    high = 4'd0; low = 4'd5;
    slot(4, 7'h12, 2'b10, 1'b1, 1'b0);
    slot2(4, 7'h7F, 2'b11, 7'h40, 2'b01, 1'b0, 1'b0);

    // Tear-free: low changes 3->9 mid HIGH slot, shows only next frame.
    high = 4'd1; low = 4'd3;
    slot(4, 7'h30, 2'b10, 1'b1, 1'b0);
    slot(2, 7'h79, 2'b01, 1'b0, 1'b0);
    low = 4'd9;
    slot(2, 7'h79, 2'b01, 1'b0, 1'b0);
    slot(4, 7'h10, 2'b10, 1'b1, 1'b0);
    slot(4, 7'h79, 2'b01, 1'b0, 1'b0);

    // Invalid codes A/C: dashes, invalid high not blanked, err for the frame.
    high = 4'hA; low = 4'hC;
    slot(4, 7'h3F, 2'b10, 1'b1, 1'b1);
    slot(4, 7'h3F, 2'b01, 1'b0, 1'b1);

    // Invalid high persists; enable drop mid-LOW holds bcd_err.
    low = 4'd2;
    slot(2, 7'h24, 2'b10, 1'b1, 1'b1);
    enable = 1'b0;
    slot(2, 7'h7F, 2'b11, 1'b0, 1'b1);

    // Re-enable: fresh valid snapshot clears err, full-length slots.
    enable = 1'b1; high = 4'd1;
    slot(4, 7'h24, 2'b10, 1'b0, 1'b0);
    slot(4, 7'h79, 2'b01, 1'b0, 1'b0);

    // Reset mid-HIGH.
    high = 4'd8; low = 4'd0;
    slot(4, 7'h40, 2'b10, 1'b1, 1'b0);
    slot(2, 7'h00, 2'b01, 1'b0, 1'b0);
    reset = 1'b0;
    slot(1, 7'h7F, 2'b11, 1'b0, 1'b0);
    reset = 1'b1;
    slot(1, 7'h40, 2'b10, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clock);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
